// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - writeback stage: ALU/load results to the register file
// Define RWB_FORWARD_EN to drive the fwd_* bypass from the write port.
module reg_writeback (
  input  logic        clkin,
  input  logic        nrst_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic [4:0]  in_rd_idx,
  input  logic [31:0] in_alu_data,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        wr_en,
  output logic [4:0]  wr_idx_out,
  output logic [31:0] wr_data_out,
  output logic        fwd_valid,
  output logic [4:0]  fwd_idx,
  output logic [31:0] fwd_data
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_MEM, DRAIN} state_t;

  state_t      state;
  logic [4:0]  ld_rd_idx;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign in_ready = (state == IDLE) || (state == WRITE);
  assign accept   = in_valid & in_ready & ~flush;

  assign load_byte = mem_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign load_half = mem_rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  // Unlisted funct3 encodings fall through to a full-word load.
  always_comb begin
    load_data = mem_rdata;
    case (ld_funct3)
      3'd0:    load_data = {{24{load_byte[7]}}, load_byte};
      3'd1:    load_data = {{16{load_half[15]}}, load_half};
      3'd4:    load_data = {24'd0, load_byte};
      3'd5:    load_data = {16'd0, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_idx_out  <= 5'd0;
      wr_data_out <= 32'd0;
      ld_rd_idx   <= 5'd0;
      ld_funct3   <= 3'd0;
      ld_addr_lo  <= 2'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          state <= IDLE;
          if (accept) begin
            if (in_is_load) begin
              ld_rd_idx  <= in_rd_idx;
              ld_funct3  <= in_funct3;
              ld_addr_lo <= in_addr_lo;
              state      <= WAIT_MEM;
            end else begin
              state <= WRITE;
              // x0 is never written; the port keeps its previous contents.
              if (in_rd_idx != 5'd0) begin
                wr_en       <= 1'b1;
                wr_idx_out  <= in_rd_idx;
                wr_data_out <= in_alu_data;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (flush) begin
            state <= mem_rvalid ? IDLE : DRAIN;
          end else if (mem_rvalid) begin
            state <= WRITE;
            if (ld_rd_idx != 5'd0) begin
              wr_en       <= 1'b1;
              wr_idx_out  <= ld_rd_idx;
              wr_data_out <= load_data;
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RWB_FORWARD_EN
  assign fwd_valid = wr_en;
  assign fwd_idx   = wr_idx_out;
  assign fwd_data  = wr_data_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_idx   = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback
// Drives on #1 after rising edges and samples outputs after the edge has settled.
module tb_reg_writeback;

  logic        clkin = 1'b0;
  logic        nrst_in;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic [4:0]  in_rd_idx;
  logic [31:0] in_alu_data;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_idx_out;
  logic [31:0] wr_data_out;
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference view of the write port contents, which persist across idle cycles.
  logic [4:0]  m_idx;
  logic [31:0] m_data;

  reg_writeback dut (
    .clkin(clkin), .nrst_in(nrst_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_rd_idx(in_rd_idx), .in_alu_data(in_alu_data), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush), .wr_en(wr_en), .wr_idx_out(wr_idx_out), .wr_data_out(wr_data_out),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data)
  );

  always #5 clkin = ~clkin;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'd255;
    h = (w >> (16 * (a / 2))) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [37:0] fwd_expect(input logic en);
`ifdef RWB_FORWARD_EN
    return {en, m_idx, m_data};
`else
    return 38'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic quiet_inputs();
    in_valid = 0; in_is_load = 0; in_rd_idx = 0; in_alu_data = 0;
    in_funct3 = 0; in_addr_lo = 0; mem_rvalid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    nrst_in = 1;
    #3 nrst_in = 0;
    #1;
    m_idx = 0; m_data = 0;
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out} !== {1'b0, 5'd0, 32'd0}) begin
      n_bad++; $display("FAIL reset_port got %b/%0d/%h want 0/0/0", wr_en, wr_idx_out, wr_data_out);
    end
    n_cmp++;
    if ({fwd_valid, fwd_idx, fwd_data} !== 38'd0) begin
      n_bad++; $display("FAIL reset_fwd got %h want 0", {fwd_valid, fwd_idx, fwd_data});
    end
    tick(); tick();
    nrst_in = 1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_alu();
    in_valid = 1; in_is_load = 0; in_rd_idx = 5; in_alu_data = 32'hDEADBEEF;
    tick();
    quiet_inputs();
    m_idx = 5; m_data = 32'hDEADBEEF;
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL alu_write got %b/%0d/%h want 1/5/deadbeef", wr_en, wr_idx_out, wr_data_out);
    end
    tick();
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL alu_hold got %b/%0d/%h want 0/5/deadbeef", wr_en, wr_idx_out, wr_data_out);
    end
  endtask

  task automatic test_rd0();
    in_valid = 1; in_is_load = 0; in_rd_idx = 0; in_alu_data = 32'h1234;
    tick();
    in_rd_idx = 9; in_alu_data = 32'h0BAD_F00D;
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out, in_ready} !== {1'b0, m_idx, m_data, 1'b1}) begin
      n_bad++; $display("FAIL rd0_nowrite got %b/%0d/%h rdy %b want 0/%0d/%h rdy 1",
                        wr_en, wr_idx_out, wr_data_out, in_ready, m_idx, m_data);
    end
    tick();
    quiet_inputs();
    m_idx = 9; m_data = 32'h0BAD_F00D;
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out} !== {1'b1, m_idx, m_data}) begin
      n_bad++; $display("FAIL rd0_next got %b/%0d/%h want 1/9/0badf00d", wr_en, wr_idx_out, wr_data_out);
    end
    tick();
  endtask

  task automatic test_loads();
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [4:0]  rd;
    logic [31:0] w, exp;
    int          dly;
    for (int k = 0; k < 30; k++) begin
      if (k == 0)      begin f3 = 0; a = 3; rd = 7;  w = 32'h80FF_1234; dly = 4; end
      else if (k == 1) begin f3 = 5; a = 2; rd = 8;  w = 32'h8001_0000; dly = 1; end
      else if (k == 2) begin f3 = 1; a = 2; rd = 10; w = 32'h8001_0000; dly = 0; end
      else if (k == 3) begin f3 = 2; a = 1; rd = 0;  w = 32'hCAFE_0001; dly = 2; end
      else begin
        f3 = 3'($urandom_range(0, 7)); a = 2'($urandom); rd = 5'($urandom);
        w = $urandom; dly = $urandom_range(0, 5);
      end
      exp = load_value(f3, a, w);
      if (k == 0 && exp !== 32'hFFFF_FF80) $display("note: load model LB gives %h", exp);
      in_valid = 1; in_is_load = 1; in_rd_idx = rd; in_funct3 = f3; in_addr_lo = a;
      in_alu_data = $urandom; mem_rvalid = 1; mem_rdata = $urandom;
      tick();
      // Scramble the request fields and keep offering ALU work: none may be taken.
      mem_rvalid = 0; in_is_load = 0; in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
      in_rd_idx = 5'($urandom | 1); in_alu_data = $urandom;
      for (int i = 0; i < dly; i++) begin
        n_cmp++;
        if ({in_ready, wr_en} !== 2'b00) begin
          n_bad++; $display("FAIL load_wait[%0d] rdy %b wr_en %b want 0 0", k, in_ready, wr_en);
        end
        tick();
      end
      mem_rvalid = 1; mem_rdata = w;
      tick();
      quiet_inputs();
      if (rd != 0) begin m_idx = rd; m_data = exp; end
      n_cmp++;
      if ({wr_en, wr_idx_out, wr_data_out, in_ready} !== {rd != 0, m_idx, m_data, 1'b1}) begin
        n_bad++; $display("FAIL load_write[%0d] f3 %0d a %0d got %b/%0d/%h rdy %b want %b/%0d/%h rdy 1",
                          k, f3, a, wr_en, wr_idx_out, wr_data_out, in_ready, rd != 0, m_idx, m_data);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b0) begin
        n_bad++; $display("FAIL load_single[%0d] wr_en %b want 0", k, wr_en);
      end
    end
  endtask

  task automatic test_flush();
    in_valid = 1; in_is_load = 1; in_rd_idx = 12; in_funct3 = 2;
    tick();
    in_is_load = 0; in_alu_data = 32'h5555_AAAA;
    tick(); tick();
    flush = 1;
    tick();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({in_ready, wr_en} !== 2'b00) begin
        n_bad++; $display("FAIL flush_drain[%0d] rdy %b wr_en %b want 0 0", i, in_ready, wr_en);
      end
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    tick();
    quiet_inputs();
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out, in_ready} !== {1'b0, m_idx, m_data, 1'b1}) begin
      n_bad++; $display("FAIL flush_nowrite got %b/%0d/%h rdy %b want 0/%0d/%h rdy 1",
                        wr_en, wr_idx_out, wr_data_out, in_ready, m_idx, m_data);
    end
  endtask

  task automatic test_back_to_back();
    logic       v, fl, acc;
    logic [4:0] rd;
    logic [31:0] d;
    for (int k = 0; k < 40; k++) begin
      v = ($urandom % 4) != 0; fl = ($urandom % 5) == 0;
      rd = 5'($urandom); d = $urandom;
      in_valid = v; flush = fl; in_is_load = 0; in_rd_idx = rd; in_alu_data = d;
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", k, in_ready);
      end
      tick();
      acc = v & ~fl;
      if (acc && rd != 0) begin m_idx = rd; m_data = d; end
      n_cmp++;
      if ({wr_en, wr_idx_out, wr_data_out} !== {acc && rd != 0, m_idx, m_data}) begin
        n_bad++; $display("FAIL b2b_write[%0d] got %b/%0d/%h want %b/%0d/%h",
                          k, wr_en, wr_idx_out, wr_data_out, acc && rd != 0, m_idx, m_data);
      end
      n_cmp++;
      if ({fwd_valid, fwd_idx, fwd_data} !== fwd_expect(acc && rd != 0)) begin
        n_bad++; $display("FAIL b2b_fwd[%0d] got %h want %h", k, {fwd_valid, fwd_idx, fwd_data},
                          fwd_expect(acc && rd != 0));
      end
    end
    quiet_inputs();
    tick();
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1; in_is_load = 1; in_rd_idx = 4; in_funct3 = 2;
    tick();
    quiet_inputs();
    tick(); tick();
    #2 nrst_in = 0;
    #1;
    m_idx = 0; m_data = 0;
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid_async got %b/%0d/%h rdy %b want 0/0/0 rdy 1",
                        wr_en, wr_idx_out, wr_data_out, in_ready);
    end
    #2 nrst_in = 1;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
    tick();
    quiet_inputs();
    n_cmp++;
    if ({wr_en, wr_idx_out, wr_data_out, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_bad++; $display("FAIL rst_mid_ignore got %b/%0d/%h rdy %b want 0/0/0 rdy 1",
                        wr_en, wr_idx_out, wr_data_out, in_ready);
    end
    n_cmp++;
    if ({fwd_valid, fwd_idx, fwd_data} !== fwd_expect(1'b0)) begin
      n_bad++; $display("FAIL rst_mid_fwd got %h want %h", {fwd_valid, fwd_idx, fwd_data}, fwd_expect(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_rd0();
    test_loads();
    test_flush();
    test_back_to_back();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have port: clkin  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: nrst_in  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  retiring instruction presented.
REQ-004 SHALL have port: in_ready  output  1  block accepts in_valid this cycle.
REQ-005 SHALL have port: in_is_load  input  1  1 = result from memory load, 0 = ALU result.
REQ-006 SHALL have port: in_rd_idx  input  5  destination register index.
REQ-007 SHALL have port: in_alu_data  input  32  ALU result, used when in_is_load=0.
REQ-008 SHALL have port: in_funct3  input  3  load width/sign: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
REQ-009 SHALL have port: in_addr_lo  input  2  load address bits [1:0].
REQ-010 SHALL have port: mem_rvalid  input  1  load response valid, single-cycle pulse.
REQ-011 SHALL have port: mem_rdata  input  32  load response word, little-endian.
REQ-012 SHALL have port: flush  input  1  squash pending uncommitted load.
REQ-013 SHALL have ports: wr_en  output  1; wr_idx_out  output  5; wr_data_out  output  32  register-file write port, all registered.
REQ-014 SHALL have ports: fwd_valid  output  1; fwd_idx  output  5; fwd_data  output  32  bypass to decode.

Function
REQ-015 SHALL implement states IDLE, WRITE, WAIT_MEM, DRAIN; in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM and DRAIN.
REQ-016 SHALL accept a transfer when in_valid & in_ready & ~flush; flush with in_valid in the same cycle rejects the transfer.
REQ-017 ALU transfer accepted in cycle N SHALL give wr_en=1, wr_idx_out=in_rd_idx, wr_data_out=in_alu_data in cycle N+1 (state WRITE); back-to-back ALU transfers give one write per cycle.
REQ-018 Load transfer SHALL latch rd_idx, funct3, addr_lo, and move to WAIT_MEM; mem_rvalid in cycle M SHALL give wr_en=1 with extended data in cycle M+1 (WRITE).
REQ-019 Load extraction: LB/LBU byte = mem_rdata[8*addr_lo +: 8]; LH/LHU half = mem_rdata[16*addr_lo[1] +: 16], addr_lo[0] ignored; LW full word, addr_lo ignored.
REQ-020 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; funct3 3, 6, 7 SHALL be treated as LW.
REQ-021 WRITE with no new accepted transfer SHALL return to IDLE with wr_en=0 next cycle.
REQ-022 rd_idx=0 SHALL follow the normal state sequence, including waiting for the load response, but wr_en SHALL stay 0.
REQ-023 flush in WAIT_MEM SHALL move to DRAIN; DRAIN waits for mem_rvalid, discards the data, and returns to IDLE with no write.
REQ-024 flush in IDLE or WRITE SHALL not cancel a write already in WRITE.
REQ-025 mem_rvalid in IDLE or WRITE, or in the acceptance cycle of the load, SHALL be ignored.
REQ-026 wr_idx_out/wr_data_out SHALL hold their last values while wr_en=0.

Reset
REQ-027 nrst_in low SHALL immediately force state=IDLE, wr_en=0, wr_idx_out=0, wr_data_out=0, and clear all latched load fields, independent of clkin.
REQ-028 Reset mid-load SHALL abandon the load; a later mem_rvalid SHALL be ignored.
REQ-029 in_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-030 With macro RWB_FORWARD_EN defined, fwd_valid/fwd_idx/fwd_data SHALL equal wr_en/wr_idx_out/wr_data_out of the same cycle.
REQ-031 With RWB_FORWARD_EN undefined, the fwd_* ports SHALL exist and be tied to 0; other behaviour SHALL be unchanged.

Verification
REQ-032 ALU: rd=5, data 0xDEADBEEF accepted at N -> wr_en=1, idx 5, data 0xDEADBEEF at N+1 only.
REQ-033 Load LB, addr_lo=3, mem_rdata=0x80FF_1234 after 4 cycles -> write 0xFFFF_FF80, one cycle after mem_rvalid; in_ready=0 while waiting.
REQ-034 Load LHU, addr_lo=2, mem_rdata=0x8001_0000 -> write 0x0000_8001; LH on the same data -> 0xFFFF_8001.
REQ-035 ALU write to rd=0 with data 0x1234 -> wr_en stays 0; the next transfer is accepted the following cycle.
REQ-036 Load pending, flush pulse, then mem_rvalid -> no write; in_ready returns to 1 one cycle after mem_rvalid.
REQ-037 nrst_in low mid-WAIT_MEM, then mem_rvalid -> outputs zero, no write, in_ready=1; fwd_* match wr_* only with RWB_FORWARD_EN defined.
